// File: rtl/history_checkpoint_queue_pkg.sv
// ============================================================================
// Module  : hist_pkg
// Brief   : Shared types and helpers for the history checkpoint queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef NUM_PERCEPTRONS
`define NUM_PERCEPTRONS 8
`endif

package hist_pkg;

  localparam int HIST_W = `NUM_PERCEPTRONS;

  typedef struct packed {
    logic [HIST_W-1:0] snap;
    logic              ptaken;
  } ckpt_entry_t;

  function automatic logic [HIST_W-1:0] shift_in(input logic [HIST_W-1:0] hist,
                                                 input logic              b);
    return {hist[HIST_W-2:0], b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/history_checkpoint_queue_if.sv
// ============================================================================
// Module  : history_checkpoint_queue_if
// Brief   : Prediction/resolution handshake and history outputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface history_checkpoint_queue_if #(
  parameter int N     = 8,
  parameter int DEPTH = 16
);
  logic                       pred_valid;
  logic                       pred_taken;
  logic                       pred_ready;
  logic                       res_valid;
  logic                       res_taken;
  logic [N-1:0]               spec_hist;
  logic                       mispredict;
  logic [N-1:0]               restore_hist;
  logic [$clog2(DEPTH):0]     count;
  logic                       underflow;

  modport master (
    output pred_valid, pred_taken, res_valid, res_taken,
    input  pred_ready, spec_hist, mispredict, restore_hist, count, underflow
  );

  modport slave (
    input  pred_valid, pred_taken, res_valid, res_taken,
    output pred_ready, spec_hist, mispredict, restore_hist, count, underflow
  );
endinterface

`default_nettype wire

// File: rtl/history_checkpoint_queue_ckpt_ring.sv
// ============================================================================
// Module  : ckpt_ring
// Brief   : DEPTH-entry circular buffer of checkpoints with push/pop/flush_to.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ckpt_ring
  import hist_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  wire                       clk,
  input  wire                       rst,
  input  wire                       push,
  input  ckpt_entry_t               push_data,
  input  wire                       pop,
  input  wire                       flush,
  input  wire [$clog2(DEPTH)-1:0]   flush_ptr,
  output ckpt_entry_t               rd_data,
  output logic [$clog2(DEPTH)-1:0]  rd_ptr,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  ckpt_entry_t   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Entry storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (flush) begin
        r_wr_ptr <= flush_ptr;
        r_count  <= '0;
      end else begin
        if (push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign rd_ptr  = r_rd_ptr;
  assign count   = r_count;
  assign full    = (r_count == c_depth);
  assign empty   = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/history_checkpoint_queue.sv
// ============================================================================
// Module  : history_checkpoint_queue
// Brief   : Speculative global history with per-branch checkpoints and
//           mispredict repair. Optional counters: HIST_CKPT_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module history_checkpoint_queue
  import hist_pkg::*;
#(
  parameter int N     = HIST_W,
  parameter int DEPTH = 16
) (
  input  wire                         clk,
  input  wire                         rst,
`ifdef HIST_CKPT_STATS_EN
  output logic [31:0]                 stat_resolved,
  output logic [31:0]                 stat_mispred,
`endif
  history_checkpoint_queue_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);

  logic [N-1:0]         r_spec_hist;
  logic                 r_mispredict;
  logic [N-1:0]         r_restore_hist;
  logic                 r_underflow;

  ckpt_entry_t          w_rd_data;
  ckpt_entry_t          w_push_data;
  logic [PW-1:0]        w_rd_ptr;
  logic [PW:0]          w_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_mis;
  logic                 w_push;
  logic [N-1:0]         w_restore;

  assign w_pop       = bus.res_valid && !w_empty;
  assign w_mis       = w_pop && (bus.res_taken != w_rd_data.ptaken);
  // A mispredict flushes the wrong path, so a concurrent push is dropped.
  assign w_push      = bus.pred_valid && !w_full && !w_mis;
  assign w_restore   = shift_in(w_rd_data.snap, bus.res_taken);
  assign w_push_data = '{snap: r_spec_hist, ptaken: bus.pred_taken};

  ckpt_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (w_mis),
    .flush_ptr (w_rd_ptr + 1'b1),
    .rd_data   (w_rd_data),
    .rd_ptr    (w_rd_ptr),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spec_hist    <= '0;
      r_mispredict   <= 1'b0;
      r_restore_hist <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_mispredict <= w_mis;
      if (w_mis) begin
        r_spec_hist    <= w_restore;
        r_restore_hist <= w_restore;
      end else if (w_push) begin
        r_spec_hist <= shift_in(r_spec_hist, bus.pred_taken);
      end
      if (bus.res_valid && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

`ifdef HIST_CKPT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (w_pop && (stat_resolved != 32'hFFFF_FFFF)) begin
        stat_resolved <= stat_resolved + 32'd1;
      end
      if (w_mis && (stat_mispred != 32'hFFFF_FFFF)) begin
        stat_mispred <= stat_mispred + 32'd1;
      end
    end
  end
`endif

  assign bus.pred_ready   = !w_full;
  assign bus.spec_hist    = r_spec_hist;
  assign bus.mispredict   = r_mispredict;
  assign bus.restore_hist = r_restore_hist;
  assign bus.count        = w_count;
  assign bus.underflow    = r_underflow;

endmodule

`default_nettype wire

// File: doc/history_checkpoint_queue.md
Name: history_checkpoint_queue

Overview:
- Speculative-side companion to the global history shift register.
- Maintains the speculative global history, updated at prediction time.
- Checkpoints the pre-prediction history of every in-flight branch in a circular queue and consumes checkpoints in order at branch resolution.
- On a mispredict it rebuilds the history with the actual outcome, flushes all younger checkpoints and drives the repaired value to the predictor front end.

Parameters:
- N, `NUM_PERCEPTRONS, history length in bits; must be >= 2.
- DEPTH, 16, max in-flight branches; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pred_valid  in  1  new prediction issued
- pred_taken  in  1  predicted direction
- pred_ready  out  1  queue can accept a prediction
- res_valid  in  1  oldest in-flight branch resolved
- res_taken  in  1  actual direction
- spec_hist  out  N  speculative history; bit 0 is newest, bit N-1 is oldest
- mispredict  out  1  registered one-cycle pulse
- restore_hist  out  N  repaired history; valid while mispredict=1
- count  out  $clog2(DEPTH)+1  occupied entries
- underflow  out  1  sticky: resolve arrived while empty

Behaviour:
- Reset (async, immediate): wr_ptr=0, rd_ptr=0, count=0, spec_hist=0, mispredict=0, restore_hist=0, underflow=0. Entry storage is not reset.
- pred_ready = (count != DEPTH), purely combinational. There is no same-cycle bypass when full, even if a pop occurs in the same cycle.
- Entry format: {snap[N-1:0], ptaken}.
- Push: when pred_valid && pred_ready and no mispredict is detected this cycle:
  - store {spec_hist, pred_taken} at wr_ptr;
  - spec_hist <= {spec_hist[N-2:0], pred_taken};
  - wr_ptr++ (wraps modulo DEPTH).
- Pop: when res_valid && count != 0:
  - read the entry at rd_ptr; rd_ptr++ (wraps).
  - If res_taken == ptaken: no other effect.
  - If res_taken != ptaken (mispredict detected):
    - next cycle mispredict=1 and restore_hist={snap[N-2:0], res_taken};
    - spec_hist <= the same value on the same edge;
    - wr_ptr <= rd_ptr+1 and count <= 0 (all younger entries flushed).
- Priority when a mispredict and a push occur in the same cycle: the flush wins. The push is dropped, since it is on the wrong path, and spec_hist takes the restore value.
- Push and correct pop in the same cycle: count is unchanged; both pointers advance.
- res_valid while count == 0: ignored. underflow <= 1 and stays 1 until reset. No state change.
- mispredict is deasserted on the cycle after its pulse. restore_hist holds its value until the next mispredict.
- Latency: spec_hist, count and mispredict are all visible 1 cycle after the triggering edge.
- Widths: count is $clog2(DEPTH)+1 bits; pointers are $clog2(DEPTH) bits and wrap naturally.
- Reset mid-operation: all in-flight checkpoints are abandoned. No mispredict pulse is generated.

Optional Feature:
- Macro: HIST_CKPT_STATS_EN.
- When defined, two extra output ports are added:
  - stat_resolved, 32 bits: counts accepted pops;
  - stat_mispred, 32 bits: counts mispredicts.
- Both counters are async-reset to 0, saturate at 2^32-1 and update on the same edge as the pop.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package hist_pkg:
  - HIST_W = `NUM_PERCEPTRONS;
  - typedef ckpt_entry_t, a packed struct {logic [HIST_W-1:0] snap; logic ptaken;};
  - function shift_in(hist, bit) returning {hist[HIST_W-2:0], bit}.
- One natural sub-module, ckpt_ring:
  - generic DEPTH-entry circular buffer of ckpt_entry_t;
  - push/pop/flush_to(ptr) interface; owns the pointers and count.
- The top level owns spec_hist, the compare logic and the mispredict/restore registers.

Test Plan:
- Reset, then 3 pushes of taken (1,1,1) with N=8 -> spec_hist=8'h07, count=3; the stored snapshots are 00, 01, 03.
- Fill DEPTH=16 pushes -> pred_ready=0 at count=16. A 17th pred_valid is ignored and spec_hist is unchanged. One correct pop -> pred_ready=1.
- Push T,T,N (spec_hist=06), then resolve the first entry with taken=0:
  - next cycle mispredict=1, restore_hist=8'h00, spec_hist=8'h00, count=0;
  - pulse lasts 1 cycle.
- Mispredicting resolve concurrent with pred_valid=1, pred_taken=1 -> push dropped, count=0, spec_hist=restore value.
- res_valid with count=0 -> underflow=1 sticky; pointers and spec_hist unchanged; rst clears it asynchronously mid-cycle.
- With HIST_CKPT_STATS_EN: 5 resolves, 2 of them mispredicts -> stat_resolved=5, stat_mispred=2. Pointer wrap check: push/pop 40 times alternately, then verify count=0 and the snapshot order is preserved.
